// File: rtl/idb_weight_sequencer.sv
// idb_weight_sequencer
// Front-end controller for one identity bottleneck block. A single serial
// weight stream is steered to the conv1, conv2 and conv3 weight ports in
// that order. The pixel gate is then opened for exactly one feature map,
// and completion is reported with a one-cycle done pulse.
//
// Optional build macro: IDB_SEQ_ERR_CHECK_EN
//   defined   : err is a sticky flag. It is set by a weight offered while
//               weights are not being accepted outside IDLE, or by start
//               while busy.
//   undefined : err is tied low and no checking logic is built.
// The data path behaves the same way in both builds.

module idb_weight_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int CH_IN        = 256,
  parameter int W1_NUM       = 16384,
  parameter int W2_NUM       = 36864,
  parameter int W3_NUM       = 16384,
  parameter int PXL_NUM      = IMAGE_WIDTH * IMAGE_HEIGHT * CH_IN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic                  weight_ready,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  valid_weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic                  valid_weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic                  valid_weight_out3,
  output logic [DATA_WIDTH-1:0] weight_out3,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One counter serves every phase. It is sized for the largest terminal
  // count, so a single width is enough. Because the counter clears on its
  // terminal count, it never wraps.
  localparam int MAX_W12 = (W1_NUM > W2_NUM) ? W1_NUM : W2_NUM;
  localparam int MAX_W   = (MAX_W12 > W3_NUM) ? MAX_W12 : W3_NUM;
  localparam int MAX_NUM = (MAX_W > PXL_NUM) ? MAX_W : PXL_NUM;
  localparam int CNT_W   = $clog2(MAX_NUM + 1);

  // Terminal counts are compared as "last index" values. This keeps the
  // compare at the counter width.
  localparam logic [CNT_W-1:0] W1_LAST  = CNT_W'(W1_NUM - 1);
  localparam logic [CNT_W-1:0] W2_LAST  = CNT_W'(W2_NUM - 1);
  localparam logic [CNT_W-1:0] W3_LAST  = CNT_W'(W3_NUM - 1);
  localparam logic [CNT_W-1:0] PXL_LAST = CNT_W'(PXL_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_LOAD3 = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  vw1_q, vw1_d;
  logic                  vw2_q, vw2_d;
  logic                  vw3_q, vw3_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d;
  logic [DATA_WIDTH-1:0] w2_q, w2_d;
  logic [DATA_WIDTH-1:0] w3_q, w3_d;
  logic                  vo_q, vo_d;
  logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
  logic                  done_q, done_d;

  logic                  w_accept;

  // weight_ready is decoded straight from the state register. The DMA
  // therefore sees the handshake in the same cycle it offers a word.
  assign weight_ready = (state_q == S_LOAD1) || (state_q == S_LOAD2) ||
                        (state_q == S_LOAD3);
  assign w_accept     = weight_ready && valid_weight_in;
  assign busy         = (state_q != S_IDLE);

  assign valid_weight_out1 = vw1_q;
  assign valid_weight_out2 = vw2_q;
  assign valid_weight_out3 = vw3_q;
  assign weight_out1       = w1_q;
  assign weight_out2       = w2_q;
  assign weight_out3       = w3_q;
  assign valid_out         = vo_q;
  assign pxl_out           = pxl_q;
  assign done              = done_q;

  // Next-state, counter and registered-output decode for the sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vw1_d   = 1'b0;
    vw2_d   = 1'b0;
    vw3_d   = 1'b0;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    vo_d    = 1'b0;
    pxl_d   = pxl_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD1;
          cnt_d   = '0;
        end
      end

      S_LOAD1: begin
        if (w_accept) begin
          vw1_d = 1'b1;
          w1_d  = weight_in;
          if (cnt_q == W1_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD2;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_LOAD2: begin
        if (w_accept) begin
          vw2_d = 1'b1;
          w2_d  = weight_in;
          if (cnt_q == W2_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD3;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_LOAD3: begin
        if (w_accept) begin
          vw3_d = 1'b1;
          w3_d  = weight_in;
          if (cnt_q == W3_LAST) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_RUN: begin
        if (valid_in) begin
          vo_d  = 1'b1;
          pxl_d = pxl_in;
          if (cnt_q == PXL_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      // Pixels still arriving here belong past the frame and are dropped.
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers. Reset clears everything, data
  // included, so outputs read as zero in the cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vw1_q   <= 1'b0;
      vw2_q   <= 1'b0;
      vw3_q   <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      vo_q    <= 1'b0;
      pxl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vw1_q   <= vw1_d;
      vw2_q   <= vw2_d;
      vw3_q   <= vw3_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      vo_q    <= vo_d;
      pxl_q   <= pxl_d;
      done_q  <= done_d;
    end
  end

`ifdef IDB_SEQ_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky protocol flag: a stray weight outside IDLE, or a restart while busy
  always_comb begin
    err_d = err_q;
    if (busy && ((valid_weight_in && !weight_ready) || start)) begin
      err_d = 1'b1;
    end
  end

  // err register; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_idb_weight_sequencer.sv
// Testbench for idb_weight_sequencer with small frame sizes
// (W1=4, W2=9, W3=4, PXL=8).
// The reference model counts loaded words and forwarded pixels and derives
// every output from those counts. It is checked every cycle and backed by
// literal expectations taken from the test plan.

module tb_idb_weight_sequencer;

  localparam int DW    = 32;
  localparam int W1    = 4;
  localparam int W2    = 9;
  localparam int W3    = 4;
  localparam int PXL   = 8;
  localparam int TOTAL = W1 + W2 + W3;

`ifdef IDB_SEQ_ERR_CHECK_EN
  localparam logic EXP_ERR_ON = 1'b1;
`else
  localparam logic EXP_ERR_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          valid_weight_in;
  logic [DW-1:0] weight_in;
  logic          weight_ready;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic          valid_weight_out1, valid_weight_out2, valid_weight_out3;
  logic [DW-1:0] weight_out1, weight_out2, weight_out3;
  logic          valid_out;
  logic [DW-1:0] pxl_out;
  logic          busy;
  logic          done;
  logic          err;

  idb_weight_sequencer #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (2),
    .IMAGE_HEIGHT(2),
    .CH_IN       (2),
    .W1_NUM      (W1),
    .W2_NUM      (W2),
    .W3_NUM      (W3),
    .PXL_NUM     (PXL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .valid_weight_in  (valid_weight_in),
    .weight_in        (weight_in),
    .weight_ready     (weight_ready),
    .valid_in         (valid_in),
    .pxl_in           (pxl_in),
    .valid_weight_out1(valid_weight_out1),
    .weight_out1      (weight_out1),
    .valid_weight_out2(valid_weight_out2),
    .weight_out2      (weight_out2),
    .valid_weight_out3(valid_weight_out3),
    .weight_out3      (weight_out3),
    .valid_out        (valid_out),
    .pxl_out          (pxl_out),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a session is either inactive or active. While active,
  // the first TOTAL accepted words are weights, routed by index range, and
  // then PXL pixels pass. One extra finishing cycle follows, which raises done.
  bit            m_active, m_fin;
  int            m_loaded, m_pix;
  logic          m_vw1, m_vw2, m_vw3, m_vo, m_done, m_busy, m_ready, m_err;
  logic [DW-1:0] m_w1, m_w2, m_w3, m_pxl;

  initial begin
    m_active = 0; m_fin = 0; m_loaded = 0; m_pix = 0;
    m_vw1 = 0; m_vw2 = 0; m_vw3 = 0; m_vo = 0; m_done = 0;
    m_busy = 0; m_ready = 0; m_err = 0;
    m_w1 = '0; m_w2 = '0; m_w3 = '0; m_pxl = '0;
  end

  always @(posedge clk) begin
    bit rdy_pre;
    rdy_pre = m_active && !m_fin && (m_loaded < TOTAL);
    if (reset) begin
      m_active = 0; m_fin = 0; m_loaded = 0; m_pix = 0;
      m_vw1 = 0; m_vw2 = 0; m_vw3 = 0; m_vo = 0; m_done = 0; m_err = 0;
      m_w1 = '0; m_w2 = '0; m_w3 = '0; m_pxl = '0;
    end else begin
      if (EXP_ERR_ON && m_active && ((valid_weight_in && !rdy_pre) || start)) m_err = 1;
      m_vw1 = 0; m_vw2 = 0; m_vw3 = 0; m_vo = 0; m_done = 0;
      if (m_active && m_fin) begin
        m_done = 1; m_active = 0; m_fin = 0;
      end else if (!m_active) begin
        if (start) begin m_active = 1; m_loaded = 0; m_pix = 0; end
      end else if (m_loaded < TOTAL) begin
        if (valid_weight_in) begin
          if (m_loaded < W1)           begin m_vw1 = 1; m_w1 = weight_in; end
          else if (m_loaded < W1 + W2) begin m_vw2 = 1; m_w2 = weight_in; end
          else                         begin m_vw3 = 1; m_w3 = weight_in; end
          m_loaded++;
        end
      end else if (valid_in) begin
        m_vo = 1; m_pxl = pxl_in; m_pix++;
        if (m_pix == PXL) m_fin = 1;
      end
    end
    m_busy  = m_active;
    m_ready = m_active && !m_fin && (m_loaded < TOTAL);
  end

  // Every-cycle compare against the model, plus capture of output streams
  logic [DW-1:0] q1[$], q2[$], q3[$], qp[$];
  int done_cnt = 0;
  int cyc_n = 0;
  int last_vo_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("weight_ready", {31'd0, weight_ready}, {31'd0, m_ready});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("valid_weight_out1", {31'd0, valid_weight_out1}, {31'd0, m_vw1});
      chk("valid_weight_out2", {31'd0, valid_weight_out2}, {31'd0, m_vw2});
      chk("valid_weight_out3", {31'd0, valid_weight_out3}, {31'd0, m_vw3});
      chk("weight_out1", weight_out1, m_w1);
      chk("weight_out2", weight_out2, m_w2);
      chk("weight_out3", weight_out3, m_w3);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_vo});
      chk("pxl_out", pxl_out, m_pxl);
      if (valid_weight_out1) q1.push_back(weight_out1);
      if (valid_weight_out2) q2.push_back(weight_out2);
      if (valid_weight_out3) q3.push_back(weight_out3);
      if (valid_out) begin qp.push_back(pxl_out); last_vo_cyc = cyc_n; end
      if (done) begin done_cnt++; done_cyc = cyc_n; end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q1.delete(); q2.delete(); q3.delete(); qp.delete();
  endtask

  task automatic chk_seq(input string nm, input logic [DW-1:0] q[$], input int first, input int n);
    chk({nm, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk(nm, q[i], first + i);
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_cnt == prev && k < 50) begin cyc(); k++; end
    chk("done_seen", done_cnt, prev + 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_ready"}, {31'd0, weight_ready}, 0);
    chk({nm, "_vw"}, {29'd0, valid_weight_out1, valid_weight_out2, valid_weight_out3}, 0);
    chk({nm, "_w1"}, weight_out1, 0);
    chk({nm, "_w2"}, weight_out2, 0);
    chk({nm, "_w3"}, weight_out3, 0);
    chk({nm, "_vo"}, {31'd0, valid_out}, 0);
    chk({nm, "_pxl"}, pxl_out, 0);
    chk({nm, "_done"}, {31'd0, done}, 0);
    chk({nm, "_err"}, {31'd0, err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; valid_weight_in = 1'b0; weight_in = '0;
    valid_in = 1'b0; pxl_in = '0;
    repeat (2) cyc();
    chk_en = 1'b1;
    cyc();
    chk_all_zero("reset");
    reset = 1'b0;
    cyc();

    // A: back-to-back weights 1..17, then 10 pixels 0xA0..0xA9
    clear_q();
    start = 1'b1; cyc(); start = 1'b0;
    chk("A_busy_after_start", {31'd0, busy}, 1);
    chk("A_ready_after_start", {31'd0, weight_ready}, 1);
    for (int w = 1; w <= TOTAL; w++) begin
      valid_weight_in = 1'b1; weight_in = w; cyc();
      if (w <= 4) begin
        chk("A_lag_port1", {valid_weight_out1, weight_out1[30:0]}, {1'b1, 31'(w)});
      end else if (w <= 13) begin
        chk("A_lag_port2", {valid_weight_out2, weight_out2[30:0]}, {1'b1, 31'(w)});
      end else begin
        chk("A_lag_port3", {valid_weight_out3, weight_out3[30:0]}, {1'b1, 31'(w)});
      end
    end
    valid_weight_in = 1'b0;
    chk("A_ready_fell", {31'd0, weight_ready}, 0);
    chk("A_busy_in_run", {31'd0, busy}, 1);
    dc = done_cnt;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; pxl_in = 32'hA0 + i; cyc();
    end
    valid_in = 1'b0;
    wait_done(dc);
    chk("A_done_lag", done_cyc - last_vo_cyc, 1);
    chk("A_busy_after_done", {31'd0, busy}, 0);
    chk_seq("A_port1", q1, 1, 4);
    chk_seq("A_port2", q2, 5, 9);
    chk_seq("A_port3", q3, 14, 4);
    chk_seq("A_pixels", qp, 32'hA0, 8);
    cyc(); cyc();
    chk("A_single_done", done_cnt, dc + 1);

    // B: gapped weights, a pixel during LOAD2, a stray weight and a start in RUN
    clear_q();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      valid_weight_in = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
      valid_weight_in = 1'b1; weight_in = 101 + i;
      if (i == 7) begin valid_in = 1'b1; pxl_in = 32'hEE; end
      cyc();
      valid_in = 1'b0;
    end
    valid_weight_in = 1'b0;
    chk("B_no_pixel_in_load", qp.size(), 0);
    valid_weight_in = 1'b1; weight_in = 32'hBAD; cyc(); valid_weight_in = 1'b0;
    chk("B_stray_weight_vw", {29'd0, valid_weight_out1, valid_weight_out2, valid_weight_out3}, 0);
    chk("B_err_after_stray", {31'd0, err}, {31'd0, EXP_ERR_ON});
    dc = done_cnt;
    for (int i = 0; i < PXL; i++) begin
      valid_in = 1'b0;
      if (i >= 4) repeat ($urandom_range(0, 2)) cyc();
      valid_in = 1'b1; pxl_in = 32'hB0 + i;
      if (i == 3) start = 1'b1;
      cyc();
      start = 1'b0;
    end
    valid_in = 1'b0;
    wait_done(dc);
    chk("B_err_after_start", {31'd0, err}, {31'd0, EXP_ERR_ON});
    chk_seq("B_port1", q1, 101, 4);
    chk_seq("B_port2", q2, 105, 9);
    chk_seq("B_port3", q3, 114, 4);
    chk_seq("B_pixels", qp, 32'hB0, 8);
    cyc();

    // C: reset after 6 weights, then a full reload from conv1
    clear_q();
    start = 1'b1; cyc(); start = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      valid_weight_in = 1'b1; weight_in = w; cyc();
    end
    valid_weight_in = 1'b0;
    reset = 1'b1; cyc();
    chk_all_zero("C_midload_reset");
    reset = 1'b0;
    cyc();
    clear_q();
    start = 1'b1; cyc(); start = 1'b0;
    for (int w = 0; w < TOTAL; w++) begin
      valid_weight_in = 1'b1; weight_in = 201 + w; cyc();
    end
    valid_weight_in = 1'b0;
    dc = done_cnt;
    for (int i = 0; i < PXL; i++) begin
      valid_in = 1'b1; pxl_in = 32'hC0 + i; cyc();
    end
    valid_in = 1'b0;
    wait_done(dc);
    chk_seq("C_port1", q1, 201, 4);
    chk_seq("C_port2", q2, 205, 9);
    chk_seq("C_port3", q3, 214, 4);
    chk_seq("C_pixels", qp, 32'hC0, 8);
    cyc(); cyc();
    chk("C_idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
